// File: rtl/sram_burst_ctrl.sv
// rtl/sram_burst_ctrl.sv - single-burst write/read controller for a single-port sync SRAM (optional SRAM_CTRL_CMP_EN read compare)
module sram_burst_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              cmd,
    input  logic              dir,
    input  logic              wrap,
    input  logic [ADDR_W-1:0] sta_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] mis_cnt,
    output logic              s_clk,
    output logic              s_cen,
    output logic              s_wen,
    output logic              s_oen,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_ddata,
    input  logic [DATA_W-1:0] s_qdata
);

    typedef enum logic [2:0] {S_IDLE, S_CHK, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              cmd_q, dir_q, wrap_q;
    logic [ADDR_W-1:0] sta_q, len_q, beat_q;
    logic [DATA_W-1:0] seed_q;
    logic              drain_q;
    logic              v0_q, v1_q;
    logic [ADDR_W-1:0] a1_q;
    logic [ADDR_W:0]   end_sum;
    logic              range_err;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] beat_data;
    logic              accept;

    assign s_clk     = clk;
    assign accept    = (state_q == S_IDLE) && start;
    // Carry out of the ADDR_W+1-bit sum means the last beat lies past DEPTH-1
    assign end_sum   = {1'b0, sta_q} + {1'b0, len_q};
    assign range_err = !wrap_q && (dir_q ? (len_q > sta_q) : end_sum[ADDR_W]);
    assign beat_addr = dir_q ? (sta_q - beat_q) : (sta_q + beat_q);
    assign beat_data = seed_q + DATA_W'(beat_q);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CHK;
            S_CHK:   state_d = range_err ? S_DONE : (cmd_q ? S_RD : S_WR);
            S_WR:    if (beat_q == len_q) state_d = S_DONE;
            S_RD:    if (beat_q == len_q) state_d = S_DRAIN;
            S_DRAIN: if (drain_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Burst parameter latch, beat counter and drain timer
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_q   <= 1'b0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
            sta_q   <= '0;
            len_q   <= '0;
            seed_q  <= '0;
            beat_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q  <= cmd;
                dir_q  <= dir;
                wrap_q <= wrap;
                sta_q  <= sta_addr;
                len_q  <= len;
                seed_q <= seed;
            end
            if (state_q == S_CHK)                         beat_q <= '0;
            else if (state_q == S_WR || state_q == S_RD)  beat_q <= beat_q + 1'b1;
            drain_q <= (state_q == S_DRAIN) ? !drain_q : 1'b0;
        end
    end

    // Registered SRAM strobes and handshake outputs, one cycle behind the state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_cen   <= 1'b1;
            s_wen   <= 1'b1;
            s_oen   <= 1'b1;
            s_addr  <= '0;
            s_ddata <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            s_cen <= !(state_q == S_WR || state_q == S_RD);
            s_wen <= !(state_q == S_WR);
            s_oen <= !(state_q == S_RD);
            if (state_q == S_WR || state_q == S_RD) s_addr <= beat_addr;
            if (state_q == S_WR)                    s_ddata <= beat_data;
            done <= (state_q == S_DONE);
            if (accept)    busy <= 1'b1;
            else if (done) busy <= 1'b0;
            if (accept)                               err <= 1'b0;
            else if (state_q == S_CHK && range_err)   err <= 1'b1;
        end
    end

    // Read pipeline: stage 0 aligns with s_addr, stage 1 with s_qdata
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            a1_q     <= '0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
        end else begin
            v0_q     <= (state_q == S_RD);
            v1_q     <= v0_q;
            a1_q     <= s_addr;
            rd_valid <= v1_q;
            if (v1_q) begin
                rd_addr <= a1_q;
                rd_data <= s_qdata;
            end
        end
    end

`ifdef SRAM_CTRL_CMP_EN
    logic [DATA_W-1:0] e0_q, e1_q;
    logic [ADDR_W-1:0] mis_q;

    assign mis_cnt = mis_q;

    // Expected pattern follows the read pipeline; saturating mismatch counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            mis_q <= '0;
        end else begin
            e0_q <= beat_data;
            e1_q <= e0_q;
            if (accept)
                mis_q <= '0;
            else if (v1_q && (s_qdata != e1_q) && (mis_q != {ADDR_W{1'b1}}))
                mis_q <= mis_q + 1'b1;
        end
    end
`else
    assign mis_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb/tb_sram_burst_ctrl.sv - scoreboard bench for sram_burst_ctrl with behavioural SRAM and burst model
module tb_sram_burst_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic clk = 1'b0;
    logic reset_n, start, cmd, dir, wrap;
    logic [ADDR_W-1:0] sta_addr, len;
    logic [DATA_W-1:0] seed;
    logic busy, done, err, rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr, mis_cnt;
    logic s_clk, s_cen, s_wen, s_oen;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_ddata, s_qdata;

    sram_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd), .dir(dir), .wrap(wrap),
        .sta_addr(sta_addr), .len(len), .seed(seed), .busy(busy), .done(done), .err(err),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr), .mis_cnt(mis_cnt),
        .s_clk(s_clk), .s_cen(s_cen), .s_wen(s_wen), .s_oen(s_oen), .s_addr(s_addr),
        .s_ddata(s_ddata), .s_qdata(s_qdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } beat_t;

    logic [DATA_W-1:0] sram    [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    beat_t wq[$];
    beat_t rq[$];
    int tests = 0;
    int fails = 0;
    bit chk_wr = 1'b1;

    // Single-port synchronous SRAM: data appears the cycle after the read edge
    always @(posedge s_clk) begin
        if (!s_cen) begin
            if (!s_wen)      sram[s_addr] <= s_ddata;
            else if (!s_oen) s_qdata <= sram[s_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected SRAM writes and read beats as the DUT presents them
    always @(negedge clk) begin
        if (reset_n) begin
            if (chk_wr && !s_cen && !s_wen) begin
                if (wq.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    beat_t b;
                    b = wq.pop_front();
                    check("wr_addr", 32'(s_addr), 32'(b.a));
                    check("wr_data", 32'(s_ddata), 32'(b.d));
                end
            end
            if (rd_valid) begin
                if (rq.size() == 0) check("unexpected_rd_valid", 1, 0);
                else begin
                    beat_t b;
                    b = rq.pop_front();
                    check("rd_addr", 32'(rd_addr), 32'(b.a));
                    check("rd_data", 32'(rd_data), 32'(b.d));
                end
            end
        end
    end

    task automatic burst(input bit c, input bit d, input bit w, input int sta, input int ln,
                         input int sd, input bit poke);
        bit e;
        int lat, exp_mis, cyc;
        bit busy_bad;
        beat_t b;
        e = 1'b0;
        if (!w) e = d ? (ln > sta) : (sta + ln > DEPTH - 1);
        exp_mis = 0;
        if (!e) begin
            for (int k = 0; k <= ln; k++) begin
                b.a = ADDR_W'(d ? sta - k : sta + k);
                b.d = DATA_W'(sd + k);
                if (!c) begin
                    wq.push_back(b);
                    ref_mem[b.a] = b.d;
                end else begin
                    if (ref_mem[b.a] != b.d) exp_mis++;
                    b.d = ref_mem[b.a];
                    rq.push_back(b);
                end
            end
        end
        if (exp_mis > DEPTH - 1) exp_mis = DEPTH - 1;
`ifndef SRAM_CTRL_CMP_EN
        exp_mis = 0;
`endif
        lat = e ? 3 : (c ? ln + 6 : ln + 4);
        cmd = c; dir = d; wrap = w;
        sta_addr = ADDR_W'(sta); len = ADDR_W'(ln); seed = DATA_W'(sd);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_bad = 1'b0;
        for (cyc = 1; cyc <= lat + 10; cyc++) begin
            if (!busy) busy_bad = 1'b1;
            if (done) break;
            if (poke) begin
                start    = (cyc == 3);
                cmd      = ~c;
                sta_addr = ADDR_W'($urandom);
                len      = ADDR_W'($urandom_range(0, 7));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_latency", cyc, lat);
        check("busy_during_burst", busy_bad, 0);
        check("err_at_done", err, e);
        check("mis_cnt_at_done", 32'(mis_cnt), exp_mis);
        @(posedge clk); #1;
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("err_held", err, e);
        check("writes_outstanding", wq.size(), 0);
        check("reads_outstanding", rq.size(), 0);
        wq.delete();
        rq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen_done;
        reset_n = 1'b0; start = 1'b0; cmd = 1'b0; dir = 1'b0; wrap = 1'b0;
        sta_addr = '0; len = '0; seed = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_cen", s_cen, 1);
        check("rst_s_wen", s_wen, 1);
        check("rst_s_oen", s_oen, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_mis_cnt", 32'(mis_cnt), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        burst(0, 0, 1, 'h3FE, 3, 'h10, 0);
        burst(1, 0, 1, 'h3FE, 3, 'h10, 0);
        burst(0, 0, 0, 'h3FE, 3, 'h10, 0);
        burst(0, 0, 0, 0, 9, 'h40, 0);
        burst(1, 1, 0, 5, 5, 'h40, 0);
        burst(1, 1, 0, 5, 6, 'h40, 0);
        sram[1]    = 8'hFF;
        ref_mem[1] = 8'hFF;
        burst(1, 0, 1, 'h3FE, 3, 'h10, 0);
        burst(0, 1, 0, 'h120, 15, 'h77, 1);
        burst(1, 1, 0, 'h120, 15, 'h77, 1);

        // Reset during a write burst: partial writes are not tracked, then overwritten
        chk_wr = 1'b0;
        cmd = 1'b0; dir = 1'b0; wrap = 1'b0; sta_addr = 'h200; len = 20; seed = 'h5A;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_wr_cen_low", s_cen, 0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("abort_s_cen", s_cen, 1);
        check("abort_busy", busy, 0);
        reset_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 0);
        chk_wr = 1'b1;
        burst(0, 0, 0, 'h200, 20, 'h5A, 0);

        burst(0, 0, 1, int'($urandom_range(0, DEPTH - 1)), DEPTH - 1, int'($urandom_range(0, 255)), 0);
        burst(1, 1, 1, int'($urandom_range(0, DEPTH - 1)), DEPTH - 1, int'($urandom_range(0, 255)), 0);

        for (int n = 0; n < 24; n++) begin
            burst(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)),
                  int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
